// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

  // Forward select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF    = 0;
  // Stage index at which an ALU result first becomes forwardable (MEM).
  localparam int unsigned ALU_AVAIL = 2;

  // Width needed to hold the largest availability stage (a load's).
  function automatic int unsigned avail_w(input int unsigned load_lat);
    return $clog2(ALU_AVAIL + load_lat + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_chain.sv
// Shift chain of scoreboard entries, one per tracked stage (index 0 = EX).
// Holds while advance is low; the oldest entry drops off the end.
module pipe_hazard_ctrl_chain #(
  parameter int STAGES = 3,
  parameter int RA_W   = 5,
  parameter int AV_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   advance,
  input  logic                   ins_valid,
  input  logic [RA_W-1:0]        ins_rd,
  input  logic                   ins_regwrite,
  input  logic [AV_W-1:0]        ins_avail,
  output logic [STAGES-1:0]      valid,
  output logic [STAGES-1:0]      regwrite,
  output logic [STAGES*RA_W-1:0] rd,
  output logic [STAGES*AV_W-1:0] avail
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the chain is a few flops rather than a RAM, so every field is reset and outputs stay defined.
      valid    <= '0;
      regwrite <= '0;
      rd       <= '0;
      avail    <= '0;
    end else if (advance) begin
      // NOTE: non-blocking so each stage captures its neighbour's value from before the edge.
      valid[0]           <= ins_valid;
      regwrite[0]        <= ins_regwrite;
      rd[RA_W-1:0]       <= ins_rd;
      avail[AV_W-1:0]    <= ins_avail;
      for (int k = 1; k < STAGES; k++) begin
        valid[k]              <= valid[k-1];
        regwrite[k]           <= regwrite[k-1];
        rd[k*RA_W +: RA_W]    <= rd[(k-1)*RA_W +: RA_W];
        avail[k*AV_W +: AV_W] <= avail[(k-1)*AV_W +: AV_W];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: EX forward selects, load-use stall, branch flush
// and multicycle freeze, all derived from the in-flight scoreboard chain.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter  int RA_W       = 5,
  parameter  int FWD_STAGES = 3,
  parameter  int LOAD_LAT   = 1,
  parameter  int MC_W       = 4,
  localparam int FS_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            id_valid_i,
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic            id_regwrite_i,
  input  logic            id_is_load_i,
  input  logic            id_branch_taken_i,
  input  logic [RA_W-1:0] ex_rs_i,
  input  logic [RA_W-1:0] ex_rt_i,
  input  logic            mc_start_i,
  input  logic [MC_W-1:0] mc_len_i,
  output logic            pc_write_o,
  output logic            ifid_write_o,
  output logic            ifid_flush_o,
  output logic            idex_bubble_o,
  output logic            freeze_o,
  output logic [FS_W-1:0] fwd_a_o,
  output logic [FS_W-1:0] fwd_b_o
);

  localparam int AV_W = int'(avail_w(LOAD_LAT));

  logic [FWD_STAGES-1:0]      e_valid;
  logic [FWD_STAGES-1:0]      e_regwrite;
  logic [FWD_STAGES*RA_W-1:0] e_rd;
  logic [FWD_STAGES*AV_W-1:0] e_avail;
  logic [AV_W-1:0]            ins_avail;
  logic [MC_W-1:0]            mc_cnt;
  logic                       freeze, stall, advance, ins_valid;
  logic                       pend_a, pend_b;
  int                         fa_k, fa_av, fb_k, fb_av, sa_k, sa_av, sb_k, sb_av;

  assign ins_avail = id_is_load_i ? AV_W'(ALU_AVAIL + LOAD_LAT) : AV_W'(ALU_AVAIL);
  assign ins_valid = id_valid_i & ~idex_bubble_o;
  assign advance   = ~freeze;

  pipe_hazard_ctrl_chain #(
    .STAGES (FWD_STAGES),
    .RA_W   (RA_W),
    .AV_W   (AV_W)
  ) u_chain (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .advance      (advance),
    .ins_valid    (ins_valid),
    .ins_rd       (id_rd_i),
    .ins_regwrite (id_regwrite_i),
    .ins_avail    (ins_avail),
    .valid        (e_valid),
    .regwrite     (e_regwrite),
    .rd           (e_rd),
    .avail        (e_avail)
  );

  // Youngest (lowest stage >= lo) entry writing src; r0 never matches. 0 = no match.
  function automatic void youngest(input logic [RA_W-1:0] src, input int lo,
                                   output int k_hit, output int av_hit);
    k_hit  = 0;
    av_hit = 0;
    for (int k = FWD_STAGES; k >= lo; k--) begin
      if (e_valid[k-1] && e_regwrite[k-1] && src != '0 && e_rd[(k-1)*RA_W +: RA_W] == src) begin
        k_hit  = k;
        av_hit = int'(e_avail[(k-1)*AV_W +: AV_W]);
      end
    end
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    stall   = 1'b0;
    pend_a  = 1'b0;
    pend_b  = 1'b0;
    fwd_a_o = FS_W'(FWD_RF);
    fwd_b_o = FS_W'(FWD_RF);
    youngest(ex_rs_i, 2, fa_k, fa_av);
    youngest(ex_rt_i, 2, fb_k, fb_av);
    youngest(id_rs_i, 1, sa_k, sa_av);
    youngest(id_rt_i, 1, sb_k, sb_av);

    // A producer at stage k reaches stage k+1 when the consumer enters EX.
    if (id_valid_i && ((sa_k != 0 && sa_k + 1 < sa_av) || (sb_k != 0 && sb_k + 1 < sb_av)))
      stall = 1'b1;

    if (fa_k != 0) begin
      if (fa_k >= fa_av) fwd_a_o = FS_W'(fa_k);
      else               pend_a  = 1'b1;
    end
    if (fb_k != 0) begin
      if (fb_k >= fb_av) fwd_b_o = FS_W'(fb_k);
      else               pend_b  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        mc_cnt <= '0;
    else if (freeze)     mc_cnt <= mc_cnt - 1'b1;
    else if (mc_start_i) mc_cnt <= mc_len_i;
  end

  assign freeze        = |mc_cnt;
  assign freeze_o      = freeze;
  assign pc_write_o    = ~freeze & ~stall;
  assign ifid_write_o  = ~freeze & ~stall;
  assign idex_bubble_o = stall & ~freeze;
  assign ifid_flush_o  = id_branch_taken_i & ~stall & ~freeze;

  a_mc_start_idle: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(mc_start_i && freeze));

  // The stall logic must keep an unavailable producer out of reach of EX.
  a_fwd_ready: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(pend_a || pend_b));

endmodule
